// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control FSM.
// CONTROL_FSM_TRAP_EN adds the TRAP state used for fault halts.
package control_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    TARGET,
    NEXTPC
`ifdef CONTROL_FSM_TRAP_EN
    , TRAP
`endif
  } state_t;

  localparam logic [1:0] INSEL1_RS1  = 2'd0;
  localparam logic [1:0] INSEL1_PC   = 2'd1;
  localparam logic [1:0] INSEL1_ZERO = 2'd2;

  localparam logic [1:0] INSEL2_RS2  = 2'd0;
  localparam logic [1:0] INSEL2_IMM  = 2'd1;
  localparam logic [1:0] INSEL2_FOUR = 2'd2;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  localparam logic RD_ALU = 1'b0;
  localparam logic RD_MEM = 1'b1;

  localparam logic [4:0] ALU_ADD = 5'b00000;

endpackage

// File: rtl/control_fsm_if.sv
// Decoded-instruction inputs and datapath strobes between control FSM and datapath.
// CONTROL_FSM_TRAP_EN adds the trap indicator.
interface control_fsm_if;
  logic       opcode_load, opcode_miscmem, opcode_opimm, opcode_auipc, opcode_store;
  logic       opcode_op, opcode_lui, opcode_branch, opcode_jalr, opcode_jal, opcode_system;
  logic       invalid_inst, ialign, mem_malign, mem_fc;
  logic [4:0] aluop_in;
  logic       branch_taken;
  logic       write_pc, write_ir, write_rd, mem_read, mem_write;
  logic [4:0] alu_op;
  logic       addr_sel, rd_sel;
  logic [1:0] alu_insel1, alu_insel2;
`ifdef CONTROL_FSM_TRAP_EN
  logic       trap;
`endif

  modport master (
    input  opcode_load, opcode_miscmem, opcode_opimm, opcode_auipc, opcode_store,
           opcode_op, opcode_lui, opcode_branch, opcode_jalr, opcode_jal, opcode_system,
           invalid_inst, ialign, mem_malign, mem_fc, aluop_in, branch_taken,
    output write_pc, write_ir, write_rd, mem_read, mem_write,
           alu_op, addr_sel, rd_sel, alu_insel1, alu_insel2
`ifdef CONTROL_FSM_TRAP_EN
    , output trap
`endif
  );

  modport slave (
    output opcode_load, opcode_miscmem, opcode_opimm, opcode_auipc, opcode_store,
           opcode_op, opcode_lui, opcode_branch, opcode_jalr, opcode_jal, opcode_system,
           invalid_inst, ialign, mem_malign, mem_fc, aluop_in, branch_taken,
    input  write_pc, write_ir, write_rd, mem_read, mem_write,
           alu_op, addr_sel, rd_sel, alu_insel1, alu_insel2
`ifdef CONTROL_FSM_TRAP_EN
    , input trap
`endif
  );

endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV32 control FSM: state register plus a state/input decode of the strobes.
// CONTROL_FSM_TRAP_EN enables fault detection and the sticky TRAP halt.
module control_fsm
  import control_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  control_fsm_if.master bus
);

  state_t state, nxt;

`ifdef CONTROL_FSM_TRAP_EN
  logic first_mem;
  logic fault;
`else
  logic unused_faults;
  assign unused_faults = ^{bus.invalid_inst, bus.ialign, bus.mem_malign};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
`ifdef CONTROL_FSM_TRAP_EN
      first_mem <= 1'b1;
`endif
    end else begin
      state     <= nxt;
`ifdef CONTROL_FSM_TRAP_EN
      // High exactly in the first cycle spent in MEM.
      first_mem <= (state != MEM);
`endif
    end
  end

  always_comb begin
    nxt            = state;
    bus.write_pc   = 1'b0;
    bus.write_ir   = 1'b0;
    bus.write_rd   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.addr_sel   = ADDR_PC;
    bus.rd_sel     = RD_ALU;
    bus.alu_insel1 = INSEL1_RS1;
    bus.alu_insel2 = INSEL2_RS2;
`ifdef CONTROL_FSM_TRAP_EN
    bus.trap       = 1'b0;
    fault          = 1'b0;
`endif
    if (!rst) begin
      case (state)
        FETCH: begin
          bus.mem_read = 1'b1;
          if (bus.mem_fc) begin
            bus.write_ir = 1'b1;
            nxt          = DECODE;
          end
        end
        DECODE: nxt = EXEC;
        EXEC: begin
          nxt = NEXTPC;
          if (bus.opcode_op || bus.opcode_opimm) begin
            bus.alu_op     = bus.aluop_in;
            bus.alu_insel2 = bus.opcode_opimm ? INSEL2_IMM : INSEL2_RS2;
            bus.write_rd   = 1'b1;
          end else if (bus.opcode_lui || bus.opcode_auipc) begin
            bus.alu_insel1 = bus.opcode_lui ? INSEL1_ZERO : INSEL1_PC;
            bus.alu_insel2 = INSEL2_IMM;
            bus.write_rd   = 1'b1;
          end else if (bus.opcode_load || bus.opcode_store) begin
            bus.alu_insel2 = INSEL2_IMM;
            nxt            = MEM;
          end else if (bus.opcode_jal || bus.opcode_jalr) begin
            bus.alu_insel1 = INSEL1_PC;
            bus.alu_insel2 = INSEL2_FOUR;
            bus.write_rd   = 1'b1;
            nxt            = TARGET;
          end else if (bus.opcode_branch) begin
            bus.alu_op = bus.aluop_in;
            nxt        = bus.branch_taken ? TARGET : NEXTPC;
          end else if (bus.opcode_miscmem || bus.opcode_system) begin
            nxt = NEXTPC;
          end
        end
        MEM: begin
          bus.addr_sel  = ADDR_ALU;
          bus.mem_read  = bus.opcode_load;
          bus.mem_write = bus.opcode_store && !bus.opcode_load;
          if (bus.mem_fc) begin
            bus.write_rd = bus.opcode_load;
            bus.rd_sel   = bus.opcode_load ? RD_MEM : RD_ALU;
            nxt          = NEXTPC;
          end
        end
        TARGET: begin
          bus.alu_insel1 = bus.opcode_jalr ? INSEL1_RS1 : INSEL1_PC;
          bus.alu_insel2 = INSEL2_IMM;
          bus.write_pc   = 1'b1;
          nxt            = FETCH;
        end
        NEXTPC: begin
          bus.alu_insel1 = INSEL1_PC;
          bus.alu_insel2 = INSEL2_FOUR;
          bus.write_pc   = 1'b1;
          nxt            = FETCH;
        end
`ifdef CONTROL_FSM_TRAP_EN
        TRAP: bus.trap = 1'b1;
`endif
        default: nxt = FETCH;
      endcase
`ifdef CONTROL_FSM_TRAP_EN
      // A fault kills this cycle's architectural side effects; selects are harmless.
      fault = (state == DECODE && bus.invalid_inst) ||
              (state == EXEC && bus.opcode_system) ||
              (state == MEM && first_mem && bus.mem_malign) ||
              ((state == TARGET || state == NEXTPC) && bus.ialign);
      if (fault) begin
        bus.write_pc  = 1'b0;
        bus.write_ir  = 1'b0;
        bus.write_rd  = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        nxt           = TRAP;
      end
`endif
    end
  end

endmodule
